// File: rtl/bus_intercept_ctrl.sv
// Read-cycle intercept controller for the 68020 bus on the CD32 riser.
// Decodes joystick/pot/CIA reads, claims them from the accelerator, drives
// the byte on D[31:24] with an 8-bit DSACK, and owns the source register bank
// that the user_io side updates. Tristate buffers live in the top level.
module bus_intercept_ctrl #(
    parameter int DSACK_WAIT = 1,
    parameter int TIMEOUT    = 15
) (
    input  logic        CLKCPU_A,
    input  logic        RESET,
    input  logic        AS20,
    input  logic        DS20,
    input  logic        RW,
    input  logic [23:0] A,
    input  logic        PUNT_IN,
    input  logic        ENABLE,
    input  logic        WR_STB,
    input  logic [1:0]  WR_SEL,
    input  logic [15:0] WR_DATA,
    output logic [7:0]  D_OUT,
    output logic        D_OE,
    output logic [1:0]  DSACK_N,
    output logic        DSACK_OE,
    output logic        PUNT_OUT,
    output logic        SRC_RD,
    output logic [1:0]  SRC_IDX,
    output logic        ERR,
    output logic        BUSY
);

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_PUNT, S_CLAIM, S_DRIVE, S_ACK, S_RELEASE
    } state_t;

    state_t      state, state_next;
    logic [15:0] bank [4];
    logic [1:0]  sel;
    logic        armed;
    logic [2:0]  wait_cnt;
    logic [7:0]  tcnt;
    logic        ack_entry;
    logic        pend_vld;
    logic [15:0] pend_data;
    logic        hit;
    logic [1:0]  idx;
    logic [7:0]  rd_byte;
    logic        timeout_hit;
    logic        claim;
    logic        in_claim;
    logic        hold_wr;
    logic [15:0] wr_val;

    // Address decode of the CPU byte address into a bank entry and byte lane
    always_comb begin
        hit = 1'b1;
        idx = 2'd0;
        case (A)
            24'hDFF00A, 24'hDFF00B: idx = 2'd0;
            24'hDFF00C, 24'hDFF00D: idx = 2'd1;
            24'hDFF012, 24'hDFF013: idx = 2'd2;
            24'hBFE001:             idx = 2'd3;
            default:                hit = 1'b0;
        endcase
        // Odd addresses are the low byte; PRA sits at an odd address so it picks [7:0]
        rd_byte = A[0] ? bank[idx][7:0] : bank[idx][15:8];
    end

    assign timeout_hit = !armed && DS20 && (tcnt == 8'(TIMEOUT - 1));
    assign in_claim    = (state == S_CLAIM) || (state == S_DRIVE) || (state == S_ACK);
    // A write to the entry currently being served is parked until RELEASE
    assign hold_wr     = WR_STB && in_claim && (WR_SEL == sel);
    assign wr_val      = (WR_SEL == 2'd3) ? {8'h00, WR_DATA[7:0]} : WR_DATA;

    // State register
    always_ff @(posedge CLKCPU_A or posedge RESET) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state logic; AS20 negation aborts any cycle not yet acknowledged
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (!AS20) state_next = S_DECODE;
            S_DECODE: begin
                if (AS20)                                       state_next = S_RELEASE;
                else if (!ENABLE || !RW || !PUNT_IN || !hit)    state_next = S_PUNT;
                else                                            state_next = S_CLAIM;
            end
            S_PUNT:    if (AS20) state_next = S_IDLE;
            S_CLAIM: begin
                if (AS20)                            state_next = S_RELEASE;
                else if (armed && wait_cnt == 3'd0)  state_next = S_DRIVE;
                else if (timeout_hit)                state_next = S_DRIVE;
            end
            S_DRIVE:   state_next = AS20 ? S_RELEASE : S_ACK;
            S_ACK:     if (AS20) state_next = S_RELEASE;
            S_RELEASE: state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Output decode from the current state
    always_comb begin
        claim    = in_claim;
        D_OE     = (state == S_DRIVE) || (state == S_ACK);
        DSACK_OE = (state == S_ACK) || (state == S_RELEASE);
        DSACK_N  = (state == S_ACK) ? 2'b10 : 2'b11;
        PUNT_OUT = PUNT_IN & ~claim;
        BUSY     = (state != S_IDLE);
        SRC_RD   = ack_entry;
        SRC_IDX  = sel;
    end

    // CLAIM timing: DS20 arms the DSACK_WAIT countdown, otherwise count toward timeout
    always_ff @(posedge CLKCPU_A or posedge RESET) begin
        if (RESET) begin
            armed    <= 1'b0;
            wait_cnt <= 3'd0;
            tcnt     <= 8'd0;
        end else if (state != S_CLAIM) begin
            armed    <= 1'b0;
            wait_cnt <= 3'd0;
            tcnt     <= 8'd0;
        end else if (!armed) begin
            if (!DS20) begin
                armed    <= 1'b1;
                wait_cnt <= 3'(DSACK_WAIT);
            end else begin
                tcnt <= tcnt + 8'd1;
            end
        end else if (wait_cnt != 3'd0) begin
            wait_cnt <= wait_cnt - 3'd1;
        end
    end

    // Claim latch, sticky timeout flag and the SRC_RD entry pulse
    always_ff @(posedge CLKCPU_A or posedge RESET) begin
        if (RESET) begin
            D_OUT     <= 8'h00;
            sel       <= 2'd0;
            ERR       <= 1'b0;
            ack_entry <= 1'b0;
        end else begin
            if (state == S_DECODE && state_next == S_CLAIM) begin
                D_OUT <= rd_byte;
                sel   <= idx;
            end
            if (state == S_CLAIM && !AS20 && timeout_hit) ERR <= 1'b1;
            ack_entry <= (state == S_DRIVE) && (state_next == S_ACK);
        end
    end

    // Register bank with one-deep pending buffer; a direct write after the commit wins
    always_ff @(posedge CLKCPU_A or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 4; i++) bank[i] <= 16'h0000;
            pend_vld  <= 1'b0;
            pend_data <= 16'h0000;
        end else begin
            if (state == S_RELEASE && pend_vld) begin
                bank[sel] <= pend_data;
                pend_vld  <= 1'b0;
            end
            if (hold_wr) begin
                pend_vld  <= 1'b1;
                pend_data <= wr_val;
            end else if (WR_STB) begin
                bank[WR_SEL] <= wr_val;
            end
        end
    end

endmodule

// File: tb/tb_bus_intercept_ctrl.sv
// Directed bench for bus_intercept_ctrl: claim/punt decisions, timing of the
// byte drive and DSACK, write arbitration, timeout, abort and reset behaviour.
module tb_bus_intercept_ctrl;

    logic        CLKCPU_A = 1'b0;
    logic        RESET, AS20, DS20, RW, PUNT_IN, ENABLE, WR_STB;
    logic [23:0] A;
    logic [1:0]  WR_SEL;
    logic [15:0] WR_DATA;
    logic [7:0]  D_OUT;
    logic        D_OE, DSACK_OE, PUNT_OUT, SRC_RD, ERR, BUSY;
    logic [1:0]  DSACK_N, SRC_IDX;

    int checks   = 0;
    int failures = 0;

    bus_intercept_ctrl #(.DSACK_WAIT(1), .TIMEOUT(15)) dut (
        .CLKCPU_A(CLKCPU_A), .RESET(RESET), .AS20(AS20), .DS20(DS20), .RW(RW),
        .A(A), .PUNT_IN(PUNT_IN), .ENABLE(ENABLE), .WR_STB(WR_STB),
        .WR_SEL(WR_SEL), .WR_DATA(WR_DATA), .D_OUT(D_OUT), .D_OE(D_OE),
        .DSACK_N(DSACK_N), .DSACK_OE(DSACK_OE), .PUNT_OUT(PUNT_OUT),
        .SRC_RD(SRC_RD), .SRC_IDX(SRC_IDX), .ERR(ERR), .BUSY(BUSY)
    );

    always #5 CLKCPU_A = ~CLKCPU_A;

    task automatic tick;
        @(posedge CLKCPU_A);
        #1;
    endtask

    task automatic write_reg(input logic [1:0] s, input logic [15:0] d);
        WR_STB = 1'b1; WR_SEL = s; WR_DATA = d;
        tick;
        WR_STB = 1'b0;
    endtask

    task automatic start_read(input logic [23:0] addr);
        A = addr; RW = 1'b1; AS20 = 1'b0; DS20 = 1'b0;
    endtask

    // From ACK: one edge to RELEASE, one to IDLE
    task automatic end_cycle;
        AS20 = 1'b1; DS20 = 1'b1;
        tick;
        tick;
    endtask

    // Edges 0..5: ends in ACK with DSACK_WAIT=1 and DS20 low throughout
    task automatic run_to_ack(input logic [23:0] addr);
        start_read(addr);
        repeat (6) tick;
    endtask

    task automatic test_reset;
        RESET = 1'b1; AS20 = 1'b1; DS20 = 1'b1; RW = 1'b1; A = 24'h0;
        PUNT_IN = 1'b1; ENABLE = 1'b1; WR_STB = 1'b0; WR_SEL = 2'd0; WR_DATA = 16'h0;
        #2;
        checks++; if (D_OE !== 1'b0) begin failures++; $display("FAIL reset_d_oe got=%b exp=0", D_OE); end
        checks++; if (DSACK_OE !== 1'b0) begin failures++; $display("FAIL reset_dsack_oe got=%b exp=0", DSACK_OE); end
        checks++; if (DSACK_N !== 2'b11) begin failures++; $display("FAIL reset_dsack_n got=%b exp=11", DSACK_N); end
        checks++; if (D_OUT !== 8'h00) begin failures++; $display("FAIL reset_d_out got=%h exp=00", D_OUT); end
        checks++; if (SRC_RD !== 1'b0 || ERR !== 1'b0 || BUSY !== 1'b0) begin failures++; $display("FAIL reset_flags got src_rd=%b err=%b busy=%b exp=000", SRC_RD, ERR, BUSY); end
        checks++; if (PUNT_OUT !== 1'b1) begin failures++; $display("FAIL reset_punt_hi got=%b exp=1", PUNT_OUT); end
        PUNT_IN = 1'b0; #1;
        checks++; if (PUNT_OUT !== 1'b0) begin failures++; $display("FAIL reset_punt_lo got=%b exp=0", PUNT_OUT); end
        PUNT_IN = 1'b1;
        tick; tick;
        RESET = 1'b0;
        tick;
    endtask

    task automatic test_claim_read;
        write_reg(2'd0, 16'h0203);
        start_read(24'hDFF00B);
        tick; // edge 0
        checks++; if (BUSY !== 1'b1 || PUNT_OUT !== 1'b1) begin failures++; $display("FAIL claim_e0 got busy=%b punt=%b exp busy=1 punt=1", BUSY, PUNT_OUT); end
        tick; // edge 1
        checks++; if (PUNT_OUT !== 1'b0) begin failures++; $display("FAIL claim_punt_out got=%b exp=0", PUNT_OUT); end
        checks++; if (D_OUT !== 8'h03) begin failures++; $display("FAIL claim_d_out got=%h exp=03", D_OUT); end
        tick; tick; // edges 2,3
        checks++; if (D_OE !== 1'b0) begin failures++; $display("FAIL claim_d_oe_e3 got=%b exp=0", D_OE); end
        tick; // edge 4
        checks++; if (D_OE !== 1'b1 || DSACK_OE !== 1'b0) begin failures++; $display("FAIL claim_e4 got d_oe=%b dsack_oe=%b exp d_oe=1 dsack_oe=0", D_OE, DSACK_OE); end
        tick; // edge 5
        checks++; if (DSACK_N !== 2'b10 || DSACK_OE !== 1'b1) begin failures++; $display("FAIL claim_dsack_e5 got n=%b oe=%b exp n=10 oe=1", DSACK_N, DSACK_OE); end
        checks++; if (SRC_RD !== 1'b1 || SRC_IDX !== 2'd0) begin failures++; $display("FAIL claim_src got rd=%b idx=%0d exp rd=1 idx=0", SRC_RD, SRC_IDX); end
        tick; // edge 6
        checks++; if (SRC_RD !== 1'b0 || D_OE !== 1'b1) begin failures++; $display("FAIL claim_e6 got src_rd=%b d_oe=%b exp src_rd=0 d_oe=1", SRC_RD, D_OE); end
        AS20 = 1'b1; DS20 = 1'b1;
        tick; // RELEASE
        checks++; if (D_OE !== 1'b0 || DSACK_OE !== 1'b1 || DSACK_N !== 2'b11 || PUNT_OUT !== 1'b1) begin failures++; $display("FAIL claim_release got d_oe=%b dsack_oe=%b n=%b punt=%b exp 0 1 11 1", D_OE, DSACK_OE, DSACK_N, PUNT_OUT); end
        tick; // IDLE
        checks++; if (DSACK_OE !== 1'b0 || BUSY !== 1'b0) begin failures++; $display("FAIL claim_idle got dsack_oe=%b busy=%b exp 0 0", DSACK_OE, BUSY); end
    endtask

    task automatic test_other_entries;
        logic [23:0] addrs [5] = '{24'hDFF00C, 24'hDFF00D, 24'hDFF012, 24'hDFF013, 24'hBFE001};
        logic [7:0]  bytes [5] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hEF};
        logic [1:0]  idxs  [5] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
        write_reg(2'd1, 16'h1234);
        write_reg(2'd2, 16'h5678);
        write_reg(2'd3, 16'hBEEF);
        for (int i = 0; i < 5; i++) begin
            start_read(addrs[i]);
            tick; tick;
            checks++; if (D_OUT !== bytes[i]) begin failures++; $display("FAIL entry_byte addr=%h got=%h exp=%h", addrs[i], D_OUT, bytes[i]); end
            repeat (4) tick;
            checks++; if (SRC_IDX !== idxs[i] || DSACK_N !== 2'b10) begin failures++; $display("FAIL entry_ack addr=%h got idx=%0d n=%b exp idx=%0d n=10", addrs[i], SRC_IDX, DSACK_N, idxs[i]); end
            end_cycle;
        end
    endtask

    task automatic test_punt_miss;
        logic bad = 1'b0;
        start_read(24'hDFF180);
        for (int i = 0; i < 6; i++) begin
            tick;
            PUNT_IN = ~PUNT_IN;
            #1;
            if (D_OE !== 1'b0 || DSACK_OE !== 1'b0 || PUNT_OUT !== PUNT_IN) bad = 1'b1;
        end
        PUNT_IN = 1'b1;
        checks++; if (bad !== 1'b0) begin failures++; $display("FAIL miss_passive got bad=%b exp=0", bad); end
        checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL miss_busy got=%b exp=1", BUSY); end
        AS20 = 1'b1; DS20 = 1'b1;
        tick;
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL miss_idle got busy=%b exp=0", BUSY); end
    endtask

    task automatic test_punt_in_low;
        logic bad = 1'b0;
        PUNT_IN = 1'b0;
        start_read(24'hDFF00A);
        for (int i = 0; i < 6; i++) begin
            tick;
            if (PUNT_OUT !== 1'b0 || D_OE !== 1'b0 || DSACK_OE !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin failures++; $display("FAIL punt_in_low got bad=%b exp=0", bad); end
        AS20 = 1'b1; DS20 = 1'b1;
        tick;
        PUNT_IN = 1'b1;
        ENABLE = 1'b0;
        start_read(24'hDFF00A);
        tick; tick; tick;
        checks++; if (PUNT_OUT !== 1'b1 || D_OE !== 1'b0) begin failures++; $display("FAIL disabled got punt=%b d_oe=%b exp 1 0", PUNT_OUT, D_OE); end
        AS20 = 1'b1; DS20 = 1'b1;
        tick;
        ENABLE = 1'b1;
    endtask

    task automatic test_pending_write;
        run_to_ack(24'hDFF00A);
        checks++; if (D_OUT !== 8'h02) begin failures++; $display("FAIL pend_initial got=%h exp=02", D_OUT); end
        write_reg(2'd0, 16'h5555);
        write_reg(2'd0, 16'hAAAA);
        write_reg(2'd1, 16'hCAFE);
        checks++; if (D_OUT !== 8'h02 || DSACK_N !== 2'b10) begin failures++; $display("FAIL pend_hold got d=%h n=%b exp d=02 n=10", D_OUT, DSACK_N); end
        end_cycle;
        run_to_ack(24'hDFF00A);
        checks++; if (D_OUT !== 8'hAA) begin failures++; $display("FAIL pend_commit_hi got=%h exp=AA", D_OUT); end
        end_cycle;
        run_to_ack(24'hDFF00C);
        checks++; if (D_OUT !== 8'hCA) begin failures++; $display("FAIL other_entry_write got=%h exp=CA", D_OUT); end
        end_cycle;
    endtask

    task automatic test_timeout;
        start_read(24'hDFF00B);
        DS20 = 1'b1;
        tick; tick;          // edges 0,1: now in CLAIM
        repeat (14) tick;    // edges 2..15
        checks++; if (D_OE !== 1'b0 || ERR !== 1'b0) begin failures++; $display("FAIL timeout_early got d_oe=%b err=%b exp 0 0", D_OE, ERR); end
        tick;                // edge 16
        checks++; if (D_OE !== 1'b1 || ERR !== 1'b1) begin failures++; $display("FAIL timeout_fire got d_oe=%b err=%b exp 1 1", D_OE, ERR); end
        tick;
        checks++; if (DSACK_N !== 2'b10 || DSACK_OE !== 1'b1 || D_OUT !== 8'hAA) begin failures++; $display("FAIL timeout_ack got n=%b oe=%b d=%h exp 10 1 AA", DSACK_N, DSACK_OE, D_OUT); end
        end_cycle;
        run_to_ack(24'hDFF00B);
        checks++; if (ERR !== 1'b1 || DSACK_N !== 2'b10) begin failures++; $display("FAIL err_sticky got err=%b n=%b exp 1 10", ERR, DSACK_N); end
        end_cycle;
    endtask

    task automatic test_abort;
        logic seen10 = 1'b0;
        start_read(24'hDFF00A);
        DS20 = 1'b1;
        tick; if (DSACK_N === 2'b10) seen10 = 1'b1;
        tick; if (DSACK_N === 2'b10) seen10 = 1'b1;
        AS20 = 1'b1;
        tick;
        if (DSACK_N === 2'b10) seen10 = 1'b1;
        checks++; if (D_OE !== 1'b0 || BUSY !== 1'b1 || PUNT_OUT !== 1'b1) begin failures++; $display("FAIL abort_release got d_oe=%b busy=%b punt=%b exp 0 1 1", D_OE, BUSY, PUNT_OUT); end
        tick;
        if (DSACK_N === 2'b10) seen10 = 1'b1;
        checks++; if (seen10 !== 1'b0 || BUSY !== 1'b0 || DSACK_OE !== 1'b0) begin failures++; $display("FAIL abort_end got seen10=%b busy=%b dsack_oe=%b exp 0 0 0", seen10, BUSY, DSACK_OE); end
    endtask

    task automatic test_back_to_back;
        run_to_ack(24'hDFF00D);
        checks++; if (D_OUT !== 8'hFE) begin failures++; $display("FAIL b2b_first got=%h exp=FE", D_OUT); end
        AS20 = 1'b1; DS20 = 1'b1;
        tick; // RELEASE
        start_read(24'hDFF00C);
        tick; // IDLE, samples AS20 low
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL b2b_idle got busy=%b exp=0", BUSY); end
        tick; tick;
        checks++; if (D_OUT !== 8'hCA || PUNT_OUT !== 1'b0) begin failures++; $display("FAIL b2b_second got d=%h punt=%b exp CA 0", D_OUT, PUNT_OUT); end
        AS20 = 1'b1; DS20 = 1'b1;
        tick; tick;
    endtask

    task automatic test_reset_mid;
        run_to_ack(24'hDFF00A);
        write_reg(2'd0, 16'h1111);
        RESET = 1'b1;
        #1;
        checks++; if (D_OE !== 1'b0 || DSACK_OE !== 1'b0 || BUSY !== 1'b0 || DSACK_N !== 2'b11) begin failures++; $display("FAIL rst_mid got d_oe=%b dsack_oe=%b busy=%b n=%b exp 0 0 0 11", D_OE, DSACK_OE, BUSY, DSACK_N); end
        checks++; if (ERR !== 1'b0 || PUNT_OUT !== 1'b1) begin failures++; $display("FAIL rst_mid_flags got err=%b punt=%b exp 0 1", ERR, PUNT_OUT); end
        AS20 = 1'b1; DS20 = 1'b1;
        tick;
        RESET = 1'b0;
        tick;
        run_to_ack(24'hDFF00A);
        checks++; if (D_OUT !== 8'h00) begin failures++; $display("FAIL rst_pending_drop got=%h exp=00", D_OUT); end
        end_cycle;
    endtask

    initial begin
        test_reset;
        test_claim_read;
        test_other_entries;
        test_punt_miss;
        test_punt_in_low;
        test_pending_write;
        test_timeout;
        test_abort;
        test_back_to_back;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
